instruction_fetch_stage: RTL

Pipeline instruction-fetch stage of the MIPS core: holds the PC, reads 32-bit instructions from the byte-wide instruction memory array, and registers them into the IF/ID pipeline register for the decode stage. It sits directly upstream of decode. It handles stall, flush and taken-branch redirect. It also raises a sticky `halted` flag after a run of consecutive NOPs or on a fetch fault, which the top level and benches use as end-of-program.

---
 rtl/instruction_fetch_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction-fetch stage: PC register, little-endian word assembly from a byte-wide memory,
// IF/ID pipeline register, stall/flush/branch handling and sticky fault/NOP-run halt flags.
module instruction_fetch_stage #(
    parameter int unsigned MEM_BYTES      = 256,
    parameter logic [31:0] PC_RESET       = 32'h0000_0000,
    parameter int unsigned NOP_HALT_COUNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  instruction_mem [MEM_BYTES],
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_error,
    output logic        halted
);

    localparam int unsigned AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
    localparam logic [2:0]  NOP_LIMIT = 3'(NOP_HALT_COUNT);

    logic [AW-1:0] base;
    logic          range_fault;
    logic [31:0]   instr;
    logic [31:0]   pc_plus4;
    logic [2:0]    nop_count;
    logic [2:0]    nop_count_next;
    logic          nop_hit;

    always_comb begin
        base        = pc[AW-1:0];
        range_fault = (pc > LAST_WORD);
        pc_plus4    = pc + 32'd4;
        instr       = '0;
        // Out-of-range addresses never index the array; the fault path squashes them.
        if (!range_fault) begin
            instr = {instruction_mem[base + AW'(3)], instruction_mem[base + AW'(2)],
                     instruction_mem[base + AW'(1)], instruction_mem[base]};
        end
        nop_count_next = (instr == '0) ? nop_count + 3'd1 : 3'd0;
        nop_hit        = (instr == '0) && (nop_count_next == NOP_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc                <= PC_RESET;
            if_id_instruction <= '0;
            if_id_pc_plus4    <= '0;
            if_id_valid       <= 1'b0;
            nop_count         <= '0;
            fetch_error       <= 1'b0;
            halted            <= 1'b0;
        end else if (halted) begin
            if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            if_id_instruction <= '0;
            if_id_pc_plus4    <= '0;
            if_id_valid       <= 1'b0;
            if (branch_target[1:0] != 2'b00) begin
                fetch_error <= 1'b1;
                halted      <= 1'b1;
            end else begin
                pc <= branch_target;
            end
        end else if (!stall) begin
            if (range_fault) begin
                if_id_instruction <= '0;
                if_id_pc_plus4    <= '0;
                if_id_valid       <= 1'b0;
                fetch_error       <= 1'b1;
                halted            <= 1'b1;
            end else if (flush) begin
                if_id_instruction <= '0;
                if_id_pc_plus4    <= '0;
                if_id_valid       <= 1'b0;
                pc                <= pc_plus4;
            end else begin
                if_id_instruction <= instr;
                if_id_pc_plus4    <= pc_plus4;
                if_id_valid       <= 1'b1;
                pc                <= pc_plus4;
                nop_count         <= nop_count_next;
                // The NOP that completes the run still loads as valid.
                if (nop_hit) begin
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule
